// File: rtl/permute_sequencer_if.sv
// Control/address bundle between the permute sequencer and its datapath/controller.
// The master drives the run request; the slave (the sequencer) drives addressing and status.
interface permute_sequencer_if #(
    parameter int SLICES = 64,
    parameter int LANES  = 25,
    parameter int RW     = 5
);
    localparam int AW = $clog2(SLICES);
    localparam int LW = $clog2(LANES);

    logic          start_i;
    logic [RW-1:0] num_rounds_i;
    logic          ld_fr_o;
    logic          en_fw_o;
    logic [AW-1:0] slice_addr_o;
    logic [LW-1:0] lane_idx_o;
    logic [RW-1:0] round_idx_o;
    logic          busy_o;
    logic          ready_o;

    modport master (
        output start_i, num_rounds_i,
        input  ld_fr_o, en_fw_o, slice_addr_o, lane_idx_o, round_idx_o, busy_o, ready_o
    );

    modport slave (
        input  start_i, num_rounds_i,
        output ld_fr_o, en_fw_o, slice_addr_o, lane_idx_o, round_idx_o, busy_o, ready_o
    );
endinterface

// File: rtl/permute_sequencer.sv
// Multi-round permute sequencer: per slice, RD_LAT read-load cycles then LANES write cycles,
// repeated over all slices for each round, ending with a one-cycle ready pulse.
module permute_sequencer #(
    parameter int SLICES = 64,
    parameter int LANES  = 25,
    parameter int RD_LAT = 2,
    parameter int RW     = 5
) (
    input  logic               clk,
    input  logic               rst,
    permute_sequencer_if.slave bus
);
    localparam int AW = $clog2(SLICES);
    localparam int LW = $clog2(LANES);
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_READ = 3'd2,
        S_CALC = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] slice_q, slice_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [RW-1:0] round_q, round_d;
    logic [RW-1:0] rounds_q, rounds_d;
    logic [CW-1:0] rd_q, rd_d;

    logic last_lane, last_slice, last_round;

    assign last_lane  = (lane_q == LW'(LANES - 1));
    assign last_slice = (slice_q == AW'(SLICES - 1));
    assign last_round = (round_q == rounds_q - RW'(1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            slice_q  <= '0;
            lane_q   <= '0;
            round_q  <= '0;
            rounds_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            slice_q  <= slice_d;
            lane_q   <= lane_d;
            round_q  <= round_d;
            rounds_q <= rounds_d;
            rd_q     <= rd_d;
        end
    end

    // NOTE: every next-state variable gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        slice_d  = slice_q;
        lane_d   = lane_q;
        round_d  = round_q;
        rounds_d = rounds_q;
        rd_d     = rd_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d  = S_ARM;
                    rounds_d = (bus.num_rounds_i == '0) ? RW'(1) : bus.num_rounds_i;
                    slice_d  = '0;
                    round_d  = '0;
                    lane_d   = '0;
                    rd_d     = '0;
                end
            end
            S_ARM: begin
                if (!bus.start_i) begin
                    state_d = S_READ;
                    rd_d    = '0;
                    lane_d  = '0;
                end
            end
            S_READ: begin
                if (rd_q == CW'(RD_LAT - 1)) begin
                    state_d = S_CALC;
                    lane_d  = '0;
                end else begin
                    rd_d = rd_q + CW'(1);
                end
            end
            S_CALC: begin
                if (!last_lane) begin
                    lane_d = lane_q + LW'(1);
                end else if (!last_slice) begin
                    state_d = S_READ;
                    slice_d = slice_q + AW'(1);
                    rd_d    = '0;
                    lane_d  = '0;
                end else if (!last_round) begin
                    state_d = S_READ;
                    slice_d = '0;
                    round_d = round_q + RW'(1);
                    rd_d    = '0;
                    lane_d  = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Final addresses stay visible during DONE and clear as IDLE is entered.
                state_d = S_IDLE;
                slice_d = '0;
                round_d = '0;
                lane_d  = '0;
                rd_d    = '0;
            end
            default: begin
                state_d = S_IDLE;
                slice_d = '0;
                round_d = '0;
                lane_d  = '0;
                rd_d    = '0;
            end
        endcase
    end

    logic          ld_fr, en_fw, busy, ready;
    logic [AW-1:0] slice_addr;
    logic [LW-1:0] lane_idx;
    logic [RW-1:0] round_idx;

    // Moore decode; IDLE and any illegal encoding keep every output at zero.
    always_comb begin
        ld_fr      = 1'b0;
        en_fw      = 1'b0;
        busy       = 1'b0;
        ready      = 1'b0;
        slice_addr = '0;
        lane_idx   = '0;
        round_idx  = '0;
        case (state_q)
            S_ARM: begin
                busy       = 1'b1;
                slice_addr = slice_q;
                round_idx  = round_q;
            end
            S_READ: begin
                ld_fr      = 1'b1;
                busy       = 1'b1;
                slice_addr = slice_q;
                round_idx  = round_q;
            end
            S_CALC: begin
                en_fw      = 1'b1;
                busy       = 1'b1;
                slice_addr = slice_q;
                lane_idx   = lane_q;
                round_idx  = round_q;
            end
            S_DONE: begin
                ready      = 1'b1;
                slice_addr = slice_q;
                round_idx  = round_q;
            end
            default: ;
        endcase
    end

    assign bus.ld_fr_o      = ld_fr;
    assign bus.en_fw_o      = en_fw;
    assign bus.busy_o       = busy;
    assign bus.ready_o      = ready;
    assign bus.slice_addr_o = slice_addr;
    assign bus.lane_idx_o   = lane_idx;
    assign bus.round_idx_o  = round_idx;
endmodule

// File: tb/tb_permute_sequencer.sv
// Bench for permute_sequencer: a small 4/3/2 instance checked cycle-by-cycle against a
// scoreboard, plus a default-parameter instance checked for total run length.
module tb_permute_sequencer;
    localparam int TS = 4;
    localparam int TL = 3;
    localparam int TR = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    permute_sequencer_if #(.SLICES(TS), .LANES(TL), .RW(5)) ia ();
    permute_sequencer_if #(.SLICES(64), .LANES(25), .RW(5)) ib ();

    permute_sequencer #(.SLICES(TS), .LANES(TL), .RD_LAT(TR), .RW(5)) u_a (
        .clk(clk), .rst(rst), .bus(ia.slave)
    );
    permute_sequencer #(.SLICES(64), .LANES(25), .RD_LAT(2), .RW(5)) u_b (
        .clk(clk), .rst(rst), .bus(ib.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pk(input logic ld, input logic en, input logic busy,
                                       input logic ready, input logic [7:0] s,
                                       input logic [7:0] l, input logic [7:0] r);
        return {ld, en, busy, ready, 4'b0, s, l, r};
    endfunction

    function automatic logic [31:0] act_a();
        return pk(ia.ld_fr_o, ia.en_fw_o, ia.busy_o, ia.ready_o,
                  8'(ia.slice_addr_o), 8'(ia.lane_idx_o), 8'(ia.round_idx_o));
    endfunction

    // Scoreboard consumer: every active cycle of instance A must match the next expected record.
    always @(negedge clk) begin
        if (rst && (ia.ld_fr_o || ia.en_fw_o || ia.ready_o)) begin
            if (sb.size() == 0) check("spurious", act_a(), 32'h0);
            else                check("seq", act_a(), sb.pop_front());
        end
    end

    task automatic start_run(input int num, input int hold, input int reff);
        @(posedge clk);
        #1;
        ia.start_i      = 1'b1;
        ia.num_rounds_i = 5'(num);
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            check("arm", act_a(), pk(0, 0, 1, 0, 0, 0, 0));
        end
        for (int r = 0; r < reff; r++) begin
            for (int s = 0; s < TS; s++) begin
                for (int k = 0; k < TR; k++) sb.push_back(pk(1, 0, 1, 0, 8'(s), 0, 8'(r)));
                for (int l = 0; l < TL; l++) sb.push_back(pk(0, 1, 1, 0, 8'(s), 8'(l), 8'(r)));
            end
        end
        sb.push_back(pk(0, 0, 0, 1, 8'(TS - 1), 0, 8'(reff - 1)));
        ia.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("first_read", {31'b0, ia.ld_fr_o}, 32'd1);
    endtask

    task automatic finish_run(input int reff);
        int k;
        k = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            k++;
            if (ia.ready_o) break;
        end
        check("run_len", k, reff * TS * (TR + TL));
        @(negedge clk);
        check("idle_after", act_a(), 32'h0);
        check("drain", sb.size(), 0);
    endtask

    initial begin
        int k;
        bit found;
        ia.start_i = 1'b0; ia.num_rounds_i = '0;
        ib.start_i = 1'b0; ib.num_rounds_i = '0;

        // Reset held for three cycles, then quiet idle.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_a", act_a(), 32'h0);
        check("rst_out_b", {ib.ld_fr_o, ib.en_fw_o, ib.busy_o, ib.ready_o}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rst_idle", act_a(), 32'h0);
        end

        // Basic two-round run, then zero rounds, then a long-held start.
        start_run(2, 2, 2);
        finish_run(2);
        start_run(0, 2, 1);
        finish_run(1);
        start_run(1, 5, 1);
        finish_run(1);

        // Abort at round 1, slice 2, lane 1.
        start_run(2, 2, 2);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ia.en_fw_o && ia.round_idx_o == 5'd1 && ia.slice_addr_o == 2'd2 &&
                ia.lane_idx_o == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_point", {31'b0, found}, 32'd1);
        rst = 1'b0;
        #1;
        check("abort_out", act_a(), 32'h0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_idle", act_a(), 32'h0);
        start_run(2, 2, 2);
        finish_run(2);

        // Default-parameter instance: 24 rounds, num_rounds disturbed mid-run.
        @(posedge clk);
        #1;
        ib.start_i      = 1'b1;
        ib.num_rounds_i = 5'd24;
        @(posedge clk);
        @(negedge clk);
        check("b_arm", {31'b0, ib.busy_o}, 32'd1);
        ib.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b_first_read", {31'b0, ib.ld_fr_o}, 32'd1);
        k = 0;
        for (int i = 0; i < 50000; i++) begin
            @(negedge clk);
            k++;
            if (k == 100) ib.num_rounds_i = 5'd3;
            if (ib.ready_o) break;
        end
        check("b_len", k, 24 * 64 * 27);
        @(negedge clk);
        check("b_idle", {ib.ld_fr_o, ib.en_fw_o, ib.busy_o, ib.ready_o}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/permute_sequencer.md
# permute_sequencer

Parametrised, multi-round successor to the single-pass permute controller in the encoder's permute stage. The block keeps its slice, lane and round counters internally and exports them as addresses. It sequences a configurable number of rounds over SLICES slices of LANES lanes each, with a configurable read latency. The block drives the permute datapath's read-register load, write enable and addressing, and reports completion to the top-level encoder controller with a one-cycle `ready` pulse.

## Interface
- SLICES, 64: slices per state; slice counter range 0..SLICES-1 (SLICES ≥ 2)
- LANES, 25: lanes per slice; lane counter range 0..LANES-1 (LANES ≥ 2)
- RD_LAT, 2: cycles `ld_fr` is held per slice before compute (RD_LAT ≥ 1)
- RW, 5: width of `num_rounds` and `round_idx`
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  level request; a run begins after it rises and then falls
- num_rounds  in  RW  round count, sampled in IDLE when `start`=1; value 0 is treated as 1
- ld_fr  out  1  load read register from the state file
- en_fw  out  1  write computed lane back to the state file
- slice_addr  out  clog2(SLICES)  current slice
- lane_idx  out  clog2(LANES)  current lane, valid while `en_fw`=1, else 0
- round_idx  out  RW  current round, 0-based
- busy  out  1  high in ARM, READ and CALC
- ready  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ARM, READ, CALC, DONE. All outputs are Moore outputs, derived only from state and counters.
- IDLE: all outputs 0.
  - start=1 → ARM; latch `num_rounds` (0→1); clear slice_addr, round_idx, rd_cnt and lane_idx.
- ARM: `busy`=1; stays in ARM while start=1; start=0 → READ.
- READ: `ld_fr`=1, `busy`=1; rd_cnt counts 0..RD_LAT-1.
  - rd_cnt=RD_LAT-1 → CALC, lane_idx=0.
- CALC: `en_fw`=1, `busy`=1; lane_idx increments each cycle.
  - On lane_idx=LANES-1, a non-last slice → slice_addr+1, READ.
  - On lane_idx=LANES-1, the last slice of a non-last round → slice_addr=0, round_idx+1, READ.
  - On lane_idx=LANES-1, the last slice of the last round → DONE.
  - rd_cnt and lane_idx clear on every entry to READ.
- DONE: `ready`=1 for exactly one cycle; → IDLE unconditionally. slice_addr and round_idx hold their final values during DONE and clear on return to IDLE.
- `start` is ignored outside IDLE and ARM. A `start` held high through DONE re-arms on the next IDLE cycle.
- Counter arithmetic: unsigned; each counter wraps only through the explicit transitions above, never by overflow.
- Illegal or unused state encodings → IDLE on the next edge, with outputs 0.
- Reset (rst=0) at any time, including mid-run: state → IDLE and all counters/outputs → 0 asynchronously; the run is abandoned with no `ready`.

## Timing
- Reset values: ld_fr=0, en_fw=0, slice_addr=0, lane_idx=0, round_idx=0, busy=0, ready=0.
- Edge E0 samples start=1 → ARM from E0. Edge Ek samples start=0 → first READ cycle from Ek.
- Per slice: RD_LAT READ cycles, then LANES CALC cycles, with no gap between slices or rounds.
- First READ cycle to the DONE cycle: R·SLICES·(RD_LAT+LANES) cycles, where R is the effective round count. `ready` is high in the cycle after the final CALC cycle.
- `busy` falls in the DONE cycle, coincident with `ready`.

## Test plan
- Reset: hold rst=0 for 3 cycles, release → all outputs 0; no activity while start=0.
- Basic run (SLICES=4, LANES=3, RD_LAT=2): num_rounds=2, start high 2 cycles then low → 40 cycles of alternating ld_fr×2 / en_fw×3; slice_addr 0..3 twice; round_idx 0 then 1; single `ready` pulse, then IDLE.
- Zero rounds: num_rounds=0 → exactly 1 round (20 cycles), then `ready`.
- Held start: start stays high 5 cycles → remains in ARM with busy=1 and no ld_fr; READ begins on the edge after start falls.
- Abort: assert rst=0 in round 1, slice 2, lane 1 → outputs 0 immediately, no `ready`; a new start runs a full 40-cycle sequence from round 0.
- Default params (64/25/2), num_rounds=24 → `ready` exactly 24·64·27=41472 cycles after the first READ cycle; num_rounds changed mid-run has no effect.
